// File: rtl/axi_wsched_pkg.sv
// Shared types and constants for the AXI write-path scheduler.
// State encoding, one-hot slave select codes and default address map.
package axi_wsched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } wsched_state_e;

   localparam logic [2:0] SEL_S0 = 3'b001;
   localparam logic [2:0] SEL_S1 = 3'b010;
   localparam logic [2:0] SEL_SD = 3'b100;

   localparam int          DEF_ADDR_W  = 32;
   localparam int          DEF_WIN_W   = 16;
   localparam logic [31:0] DEF_S0_BASE = 32'h0000_0000;
   localparam logic [31:0] DEF_S1_BASE = 32'h0001_0000;

endpackage

// File: rtl/axi_addr_decode.sv
// Combinational AW address decoder producing a one-hot slave select.
// S0 has priority over S1; anything outside both windows goes to the default slave.
module axi_addr_decode
   import axi_wsched_pkg::*;
#(
   parameter int                ADDR_W  = DEF_ADDR_W,
   parameter logic [ADDR_W-1:0] S0_BASE = DEF_S0_BASE,
   parameter logic [ADDR_W-1:0] S1_BASE = DEF_S1_BASE,
   parameter int                WIN_W   = DEF_WIN_W
) (
   input  logic [ADDR_W-1:0] addr,
   output logic [2:0]        sel
);

   always_comb begin
      sel = SEL_SD;
      if ((addr >> WIN_W) == (S0_BASE >> WIN_W)) begin
         sel = SEL_S0;
      end else if ((addr >> WIN_W) == (S1_BASE >> WIN_W)) begin
         sel = SEL_S1;
      end
   end

endmodule

// File: rtl/axi_wr_scheduler.sv
// Two-master write scheduler: round-robin AW arbitration, slave decode, and
// grant/select held through AW, W burst and B. Optional AXI_WSCHED_PERF_EN adds per-master write counters.
module axi_wr_scheduler
   import axi_wsched_pkg::*;
#(
   parameter int                ADDR_W  = DEF_ADDR_W,
   parameter logic [ADDR_W-1:0] S0_BASE = DEF_S0_BASE,
   parameter logic [ADDR_W-1:0] S1_BASE = DEF_S1_BASE,
   parameter int                WIN_W   = DEF_WIN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              awvalid_m0,
   input  logic [ADDR_W-1:0] awaddr_m0,
   output logic              awready_m0,
   input  logic              awvalid_m1,
   input  logic [ADDR_W-1:0] awaddr_m1,
   output logic              awready_m1,
   output logic [2:0]        s_awvalid,
   input  logic [2:0]        s_awready,
   input  logic              wvalid,
   input  logic              wready,
   input  logic              wlast,
   input  logic              bvalid,
   input  logic              bready,
   output logic [1:0]        grant,
   output logic [2:0]        slave_sel,
   output logic              busy
`ifdef AXI_WSCHED_PERF_EN
   ,
   output logic [15:0]       wr_cnt_m0,
   output logic [15:0]       wr_cnt_m1
`endif
);

   wsched_state_e state;
   logic          rr_last;
   logic [2:0]    sel_m0;
   logic [2:0]    sel_m1;
   logic          pick_m1;
   logic          gnt_awvalid;
   logic          sel_ready;
   logic          in_addr;
   logic          aw_hs;
   logic          w_done;
   logic          b_hs;

   axi_addr_decode #(
      .ADDR_W (ADDR_W),
      .S0_BASE(S0_BASE),
      .S1_BASE(S1_BASE),
      .WIN_W  (WIN_W)
   ) u_dec_m0 (
      .addr(awaddr_m0),
      .sel (sel_m0)
   );

   axi_addr_decode #(
      .ADDR_W (ADDR_W),
      .S0_BASE(S0_BASE),
      .S1_BASE(S1_BASE),
      .WIN_W  (WIN_W)
   ) u_dec_m1 (
      .addr(awaddr_m1),
      .sel (sel_m1)
   );

   // rr_last high means M1 was served last, so M0 wins a tie.
   always_comb begin
      pick_m1     = awvalid_m1 && (!awvalid_m0 || !rr_last);
      gnt_awvalid = (grant[0] && awvalid_m0) || (grant[1] && awvalid_m1);
      sel_ready   = |(s_awready & slave_sel);
      in_addr     = (state == ADDR);
      aw_hs       = in_addr && gnt_awvalid && sel_ready;
      w_done      = (state == DATA) && wvalid && wready && wlast;
      b_hs        = (state == RESP) && bvalid && bready;
   end

   always_comb begin
      s_awvalid  = in_addr ? (slave_sel & {3{gnt_awvalid}}) : 3'b000;
      awready_m0 = in_addr && grant[0] && sel_ready;
      awready_m1 = in_addr && grant[1] && sel_ready;
      busy       = (state != IDLE);
   end

   // Grant and select are captured once in IDLE and only cleared when B completes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         grant     <= 2'b00;
         slave_sel <= 3'b000;
         rr_last   <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (awvalid_m0 || awvalid_m1) begin
                  grant     <= pick_m1 ? 2'b10 : 2'b01;
                  slave_sel <= pick_m1 ? sel_m1 : sel_m0;
                  state     <= ADDR;
               end
            end
            ADDR: begin
               if (aw_hs) state <= DATA;
            end
            DATA: begin
               if (w_done) state <= RESP;
            end
            RESP: begin
               if (b_hs) begin
                  state     <= IDLE;
                  grant     <= 2'b00;
                  slave_sel <= 3'b000;
                  rr_last   <= grant[1];
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef AXI_WSCHED_PERF_EN
   // Saturating completed-write counters, attributed by the grant held during RESP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_cnt_m0 <= 16'h0000;
         wr_cnt_m1 <= 16'h0000;
      end else if (b_hs) begin
         if (grant[0] && wr_cnt_m0 != 16'hFFFF) wr_cnt_m0 <= wr_cnt_m0 + 16'h0001;
         if (grant[1] && wr_cnt_m1 != 16'hFFFF) wr_cnt_m1 <= wr_cnt_m1 + 16'h0001;
      end
   end
`endif

endmodule

// File: tb/tb_axi_wr_scheduler.sv
// Directed self-checking bench for axi_wr_scheduler: arbitration, decode, hold, stalls and reset.
// Counter checks are compiled in when AXI_WSCHED_PERF_EN is defined.
module tb_axi_wr_scheduler;
   import axi_wsched_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        awvalid_m0, awvalid_m1;
   logic [31:0] awaddr_m0, awaddr_m1;
   logic        awready_m0, awready_m1;
   logic [2:0]  s_awvalid;
   logic [2:0]  s_awready;
   logic        wvalid, wready, wlast, bvalid, bready;
   logic [1:0]  grant;
   logic [2:0]  slave_sel;
   logic        busy;
`ifdef AXI_WSCHED_PERF_EN
   logic [15:0] wr_cnt_m0, wr_cnt_m1;
`endif

   int checks = 0;
   int errors = 0;

   axi_wr_scheduler dut (
      .clk       (clk),
      .rst       (rst),
      .awvalid_m0(awvalid_m0),
      .awaddr_m0 (awaddr_m0),
      .awready_m0(awready_m0),
      .awvalid_m1(awvalid_m1),
      .awaddr_m1 (awaddr_m1),
      .awready_m1(awready_m1),
      .s_awvalid (s_awvalid),
      .s_awready (s_awready),
      .wvalid    (wvalid),
      .wready    (wready),
      .wlast     (wlast),
      .bvalid    (bvalid),
      .bready    (bready),
      .grant     (grant),
      .slave_sel (slave_sel),
      .busy      (busy)
`ifdef AXI_WSCHED_PERF_EN
      ,
      .wr_cnt_m0 (wr_cnt_m0),
      .wr_cnt_m1 (wr_cnt_m1)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst = 1'b0;
      awvalid_m0 = 0; awvalid_m1 = 0; awaddr_m0 = 0; awaddr_m1 = 0;
      s_awready = 0; wvalid = 0; wready = 0; wlast = 0; bvalid = 0; bready = 0;
      tick();
      tick();
      rst = 1'b1;
      tick();
   endtask

   // Entered with the DUT in ADDR for the expected master; runs AW, a burst and B.
   task automatic applyStimulus(input string tag, input logic [1:0] expGnt,
                                input logic [2:0] expSel, input int beats);
      checkOutput({tag, " grant"}, 32'(grant), 32'(expGnt));
      checkOutput({tag, " sel"}, 32'(slave_sel), 32'(expSel));
      checkOutput({tag, " s_awvalid"}, 32'(s_awvalid), 32'(expSel));
      s_awready = expSel;
      #1;
      checkOutput({tag, " awready"}, 32'({awready_m1, awready_m0}), 32'(expGnt));
      tick();
      if (expGnt[0]) awvalid_m0 = 0;
      if (expGnt[1]) awvalid_m1 = 0;
      s_awready = 0;
      checkOutput({tag, " state DATA"}, 32'(dut.state), 32'(DATA));
      for (int i = 0; i < beats; i++) begin
         wvalid = 1; wready = 1; wlast = (i == beats - 1);
         tick();
      end
      wvalid = 0; wready = 0; wlast = 0;
      bvalid = 1; bready = 1;
      checkOutput({tag, " grant in RESP"}, 32'(grant), 32'(expGnt));
      checkOutput({tag, " sel in RESP"}, 32'(slave_sel), 32'(expSel));
      tick();
      bvalid = 0; bready = 0;
      checkOutput({tag, " busy after B"}, 32'(busy), 32'd0);
      checkOutput({tag, " grant after B"}, 32'(grant), 32'd0);
      checkOutput({tag, " sel after B"}, 32'(slave_sel), 32'd0);
   endtask

   initial begin
      rst = 1'b0;
      #2;
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset grant", 32'(grant), 32'd0);
      checkOutput("reset sel", 32'(slave_sel), 32'd0);
      doReset();

      $display("[TB] test 1: M0 alone to S0");
      awvalid_m0 = 1; awaddr_m0 = 32'h0000_0040;
      #1;
      checkOutput("t1 no AW in IDLE", 32'(s_awvalid), 32'd0);
      tick();
      applyStimulus("t1", 2'b01, 3'b001, 4);

      $display("[TB] test 2: simultaneous requests to S1 from reset");
      doReset();
      awvalid_m0 = 1; awaddr_m0 = 32'h0001_0000;
      awvalid_m1 = 1; awaddr_m1 = 32'h0001_0000;
      tick();
      applyStimulus("t2 first", 2'b01, 3'b010, 2);
      tick();
      applyStimulus("t2 second", 2'b10, 3'b010, 1);
      awvalid_m0 = 1; awvalid_m1 = 1;
      tick();
      applyStimulus("t2 third", 2'b01, 3'b010, 1);
      tick();
      applyStimulus("t2 fourth", 2'b10, 3'b010, 1);

      $display("[TB] test 3: default slave decode");
      awvalid_m1 = 1; awaddr_m1 = 32'h1000_0000;
      tick();
      applyStimulus("t3", 2'b10, 3'b100, 3);
`ifdef AXI_WSCHED_PERF_EN
      checkOutput("perf m0", 32'(wr_cnt_m0), 32'd2);
      checkOutput("perf m1", 32'(wr_cnt_m1), 32'd3);
`endif

      $display("[TB] test 4: AW stall");
      awvalid_m0 = 1; awaddr_m0 = 32'h0000_1000;
      awvalid_m1 = 1; awaddr_m1 = 32'h0001_0040;
      tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("t4 state ADDR", 32'(dut.state), 32'(ADDR));
         checkOutput("t4 awready", 32'({awready_m1, awready_m0}), 32'd0);
         checkOutput("t4 grant held", 32'(grant), 32'b01);
      end
      applyStimulus("t4 m0", 2'b01, 3'b001, 1);
      tick();
      applyStimulus("t4 m1", 2'b10, 3'b010, 1);

      $display("[TB] test 5: W and B stalls");
      awvalid_m0 = 1; awaddr_m0 = 32'h0001_8000;
      tick();
      s_awready = 3'b010;
      tick();
      awvalid_m0 = 0; s_awready = 0;
      wvalid = 1; wlast = 1; wready = 0;
      tick();
      checkOutput("t5 wready low holds DATA", 32'(dut.state), 32'(DATA));
      wready = 1;
      tick();
      checkOutput("t5 moves to RESP", 32'(dut.state), 32'(RESP));
      wvalid = 0; wlast = 0; wready = 0;
      bvalid = 1; bready = 0;
      tick();
      checkOutput("t5 bready low holds RESP", 32'(dut.state), 32'(RESP));
      bready = 1;
      tick();
      bvalid = 0; bready = 0;
      checkOutput("t5 back to IDLE", 32'(dut.state), 32'(IDLE));

      $display("[TB] test 6: reset during DATA");
      awvalid_m0 = 1; awaddr_m0 = 32'h0000_0000;
      tick();
      s_awready = 3'b001;
      tick();
      s_awready = 0;
      checkOutput("t6 in DATA", 32'(dut.state), 32'(DATA));
      awvalid_m1 = 1; awaddr_m1 = 32'h0000_0080;
      rst = 1'b0;
      #1;
      checkOutput("t6 busy", 32'(busy), 32'd0);
      checkOutput("t6 grant", 32'(grant), 32'd0);
      checkOutput("t6 sel", 32'(slave_sel), 32'd0);
      checkOutput("t6 s_awvalid", 32'(s_awvalid), 32'd0);
      checkOutput("t6 awready", 32'({awready_m1, awready_m0}), 32'd0);
      tick();
      rst = 1'b1;
      awvalid_m0 = 1;
      tick();
      applyStimulus("t6 after reset", 2'b01, 3'b001, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
